instr_issue_unit: RTL and testbench
===================================

// Module: instr_issue_unit
// PURPOSE
//  In-order issue stage directly upstream of the 8-entry reorder buffer.
//  - Accepts one RV32 instruction per cycle from the fetch queue and decodes its class (LS/ADD/MULT).
//  - Allocates the ROB tail entry and a free reservation station of that class.
//  - Drives index_rb/index_rs/instruction into the ROB.
//  - Stalls on ROB-full or no free RS of the required class.
// PARAMETERS
//  ROB_DEPTH   8    ROB entries; tail pointer width is clog2(ROB_DEPTH)=3
//  XLEN        32   instruction width
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous reset, ACTIVE-HIGH (name kept per codebase)
//  in_valid      in   1   fetch queue presents an instruction
//  in_instr      in   32  instruction word
//  in_ready      out  1   issue unit accepts in_instr this cycle
//  rob_busy      in   8   {busy7..busy0} from ROB
//  rs_release    in   12  one-hot pulse; bit k frees RS id k (bit 0 unused)
//  flush         in   1   synchronous squash of all in-flight allocation state
//  issue_valid   out  1   one-cycle strobe: index_rb/index_rs/instruction valid
//  index_rb      out  3   allocated ROB entry
//  index_rs      out  4   allocated RS id: 1-6 LS, 7-9 ADD, 10-11 MULT; 0 = none
//  instruction   out  32  issued instruction word
//  rs1, rs2      out  5   source register fields of the issued instruction
//  illegal       out  1   one-cycle pulse: consumed opcode not issuable
//  stall_reason  out  2   0 none, 1 ROB full, 2 RS class full
// BEHAVIOUR
//  - Reset: all outputs 0, except in_ready, which is combinational and becomes 1 with empty masks.
//    Reset also sets tail=1 (matches ROB head reset), rs_alloc=0 and FSM=RUN.
//  - Decode, combinational on in_instr[6:0]:
//    - 0000011/0100011 -> LS.
//    - 0110011 with funct7=0000001 -> MULT.
//    - 0110011 (other funct7) or 0010011 -> ADD.
//    - Any other opcode -> ILLEGAL.
//  - RS pick: lowest free id in the class range, using the registered rs_alloc mask.
//  - rob_ok = !rob_busy[tail]. rs_ok = class has a free id; ILLEGAL counts as rs_ok.
//  - in_ready = rob_ok & rs_ok & !flush. A transfer happens when in_valid & in_ready.
//  - Latency 1. On transfer the next edge does the following:
//    - issue_valid=1; index_rb=tail; index_rs=picked id; instruction, rs1=[19:15], rs2=[24:20] registered.
//    - tail <= tail+1, wrapping 7->0.
//    - Sets rs_alloc[id].
//  - ILLEGAL transfer: illegal=1, issue_valid=0, no ROB or RS allocation, tail unchanged.
//  - No transfer: issue_valid=0. index/instruction outputs hold their last value.
//  - rs_release: clears rs_alloc bits at the edge. A released id becomes pickable the following cycle.
//    Same-cycle alloc and release of the same id cannot occur, because the picked id is already clear in rs_alloc.
//  - flush: at the edge, rs_alloc=0, tail=1, issue_valid=0 and FSM=RUN. Any in_valid that cycle is not accepted.
//  - FSM (drives stall_reason):
//    - RUN: in_valid & !rob_ok -> STALL_ROB; in_valid & rob_ok & !rs_ok -> STALL_RS.
//    - STALL_ROB: return to RUN when rob_ok, else stay.
//    - STALL_RS: -> STALL_ROB if !rob_ok; RUN when rs_ok.
//    - ROB-full takes priority in stall_reason.
//  - Reset asserted mid-operation immediately forces the reset values, including mid-stall.
// CONFIGURATION
//  ISSUE_STATS_EN defined: adds ports
//    - stat_issued (out 32): increments per issued (non-illegal) instruction.
//    - stat_stall (out 32): increments each cycle with in_valid & !in_ready.
//    - Both reset to 0, saturate at 32'hFFFF_FFFF and are not cleared by flush.
//  ISSUE_STATS_EN undefined: those ports and counters do not exist.
// STRUCTURE
//  issue_pkg: opcode constants (OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, F7_MULDIV);
//    RS id ranges (RS_LS_LO=1, RS_LS_HI=6, RS_ADD_LO=7, RS_ADD_HI=9, RS_MUL_LO=10, RS_MUL_HI=11);
//    class enum {CLS_LS, CLS_ADD, CLS_MUL, CLS_ILL}; stall_reason codes.
//  Sub-module rs_free_picker (params LO, HI): lowest-index free id in [LO,HI] plus found flag.
//    Instantiated three times, once per class.
// TESTING
//  1 After reset, ADD x3,x1,x2 valid -> next cycle issue_valid=1, index_rb=1, index_rs=7, rs1=1, rs2=2.
//  2 Four back-to-back MUL, no release -> two issue (rs 10, 11); third stalls with stall_reason=2.
//    Pulse rs_release[10] -> third issues with rs 10 one cycle later.
//  3 Eight ADDs with rs_release every cycle -> index_rb 1..7,0 (wrap).
//    Then rob_busy[1]=1 -> in_ready=0, stall_reason=1.
//  4 Opcode 7'b1111111 -> consumed, illegal=1 for one cycle, no issue, tail unchanged.
//  5 flush with all LS RS allocated and tail=5 -> next cycle tail=1, rs_alloc=0; LOAD issues with index_rs=1.
//  6 Assert rst_n mid-stall -> outputs and state return to reset values asynchronously.
//    With ISSUE_STATS_EN defined, the counters also read 0.

Source files
------------

// File: rtl/issue_pkg.sv
// Shared constants, types and decode helper for the instruction issue stage.
package issue_pkg;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned ROB_W     = $clog2(ROB_DEPTH);
    localparam int unsigned RS_N      = 12;
    localparam int unsigned RS_W      = 4;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int unsigned RS_LS_LO  = 1;
    localparam int unsigned RS_LS_HI  = 6;
    localparam int unsigned RS_ADD_LO = 7;
    localparam int unsigned RS_ADD_HI = 9;
    localparam int unsigned RS_MUL_LO = 10;
    localparam int unsigned RS_MUL_HI = 11;

    localparam logic [1:0] SR_NONE     = 2'd0;
    localparam logic [1:0] SR_ROB_FULL = 2'd1;
    localparam logic [1:0] SR_RS_FULL  = 2'd2;

    typedef enum logic [1:0] {
        CLS_LS,
        CLS_ADD,
        CLS_MUL,
        CLS_ILL
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL_ROB,
        ST_STALL_RS
    } fsm_state_t;

    function automatic instr_class_t decode_class(input logic [XLEN-1:0] instr);
        instr_class_t c;
        case (instr[6:0])
            OPC_LOAD, OPC_STORE: c = CLS_LS;
            OPC_OP:              c = (instr[31:25] == F7_MULDIV) ? CLS_MUL : CLS_ADD;
            OPC_OPIMM:           c = CLS_ADD;
            default:             c = CLS_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_issue_unit_if.sv
// Fetch-side handshake, ROB/RS status and issue bus of the issue stage.
interface instr_issue_unit_if;
    import issue_pkg::*;

    logic                in_valid;
    logic [XLEN-1:0]     in_instr;
    logic                in_ready;
    logic [ROB_DEPTH-1:0] rob_busy;
    logic [RS_N-1:0]     rs_release;
    logic                flush;
    logic                issue_valid;
    logic [ROB_W-1:0]    index_rb;
    logic [RS_W-1:0]     index_rs;
    logic [XLEN-1:0]     instruction;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic                illegal;
    logic [1:0]          stall_reason;

    // Issue unit side
    modport slave (
        input  in_valid, in_instr, rob_busy, rs_release, flush,
        output in_ready, issue_valid, index_rb, index_rs, instruction,
               rs1, rs2, illegal, stall_reason
    );

    // Environment side (fetch queue / ROB / reservation stations)
    modport master (
        output in_valid, in_instr, rob_busy, rs_release, flush,
        input  in_ready, issue_valid, index_rb, index_rs, instruction,
               rs1, rs2, illegal, stall_reason
    );

endinterface

// File: rtl/instr_issue_unit_rs_free_picker.sv
// Lowest-index free reservation station id within [LO,HI].
module rs_free_picker #(
    parameter int unsigned LO = 1,
    parameter int unsigned HI = 6
) (
    input  logic [HI:LO] alloc,
    output logic [3:0]   id,
    output logic         found
);

    // Ascending scan; the first clear bit wins
    always_comb begin
        id    = '0;
        found = 1'b0;
        for (int unsigned i = LO; i <= HI; i++) begin
            if (!found && !alloc[i]) begin
                id    = 4'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_issue_unit.sv
// In-order issue stage feeding the 8-entry ROB: decodes class, allocates the
// ROB tail and a free RS of that class, stalls on ROB-full / RS-class-full.
// Optional build macro ISSUE_STATS_EN adds saturating stat_issued/stat_stall.
// Note: rst_n is an active-high asynchronous reset (name kept for drop-in use).
module instr_issue_unit
    import issue_pkg::*;
(
    input logic clk,
    input logic rst_n,
    instr_issue_unit_if.slave bus
`ifdef ISSUE_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stall
`endif
);

    logic [ROB_W-1:0] tail;
    logic [RS_N-1:0]  rs_alloc;
    logic [RS_N-1:0]  rs_alloc_next;
    logic [RS_N-1:0]  set_mask;
    fsm_state_t       state;
    fsm_state_t       state_next;
    instr_class_t     cls;

    logic [RS_W-1:0]  ls_id, add_id, mul_id, pick_id;
    logic             ls_found, add_found, mul_found;
    logic             rob_ok, rs_ok, ready, xfer, issue_go, ill_go;

    logic             issue_valid_q, illegal_q;
    logic [ROB_W-1:0] index_rb_q;
    logic [RS_W-1:0]  index_rs_q;
    logic [XLEN-1:0]  instruction_q;
    logic [4:0]       rs1_q, rs2_q;
    logic [1:0]       stall_reason_c;

    rs_free_picker #(.LO(RS_LS_LO), .HI(RS_LS_HI)) u_pick_ls (
        .alloc (rs_alloc[RS_LS_HI:RS_LS_LO]),
        .id    (ls_id),
        .found (ls_found)
    );

    rs_free_picker #(.LO(RS_ADD_LO), .HI(RS_ADD_HI)) u_pick_add (
        .alloc (rs_alloc[RS_ADD_HI:RS_ADD_LO]),
        .id    (add_id),
        .found (add_found)
    );

    rs_free_picker #(.LO(RS_MUL_LO), .HI(RS_MUL_HI)) u_pick_mul (
        .alloc (rs_alloc[RS_MUL_HI:RS_MUL_LO]),
        .id    (mul_id),
        .found (mul_found)
    );

    // Decode class and select the picked RS id; illegal needs no RS
    always_comb begin
        cls     = decode_class(bus.in_instr);
        pick_id = '0;
        rs_ok   = 1'b1;
        case (cls)
            CLS_LS:  begin pick_id = ls_id;  rs_ok = ls_found;  end
            CLS_ADD: begin pick_id = add_id; rs_ok = add_found; end
            CLS_MUL: begin pick_id = mul_id; rs_ok = mul_found; end
            CLS_ILL: begin pick_id = '0;     rs_ok = 1'b1;      end
        endcase
    end

    assign rob_ok       = !bus.rob_busy[tail];
    assign ready        = rob_ok & rs_ok & ~bus.flush;
    assign xfer         = bus.in_valid & ready;
    assign issue_go     = xfer & (cls != CLS_ILL);
    assign ill_go       = xfer & (cls == CLS_ILL);
    assign bus.in_ready = ready;

    // Allocation mask update; a picked id is always clear, so set and
    // release of the same id never coincide
    always_comb begin
        set_mask = '0;
        if (issue_go) begin
            set_mask = RS_N'(1) << pick_id;
        end
        rs_alloc_next = (rs_alloc & ~bus.rs_release) | set_mask;
    end

    // Tail pointer, RS allocation mask and registered issue outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tail          <= ROB_W'(1);
            rs_alloc      <= '0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            index_rb_q    <= '0;
            index_rs_q    <= '0;
            instruction_q <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
        end else if (bus.flush) begin
            tail          <= ROB_W'(1);
            rs_alloc      <= '0;
            issue_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            issue_valid_q <= issue_go;
            illegal_q     <= ill_go;
            rs_alloc      <= rs_alloc_next;
            if (issue_go) begin
                tail          <= tail + ROB_W'(1);
                index_rb_q    <= tail;
                index_rs_q    <= pick_id;
                instruction_q <= bus.in_instr;
                rs1_q         <= bus.in_instr[19:15];
                rs2_q         <= bus.in_instr[24:20];
            end
        end
    end

    // Stall FSM state register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Stall FSM next state; ROB-full dominates RS-full
    always_comb begin
        state_next = state;
        if (bus.flush) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (bus.in_valid && !rob_ok) begin
                        state_next = ST_STALL_ROB;
                    end else if (bus.in_valid && !rs_ok) begin
                        state_next = ST_STALL_RS;
                    end
                end
                ST_STALL_ROB: begin
                    if (rob_ok) begin
                        state_next = ST_RUN;
                    end
                end
                ST_STALL_RS: begin
                    if (!rob_ok) begin
                        state_next = ST_STALL_ROB;
                    end else if (rs_ok) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    // Stall FSM outputs
    always_comb begin
        case (state)
            ST_STALL_ROB: stall_reason_c = SR_ROB_FULL;
            ST_STALL_RS:  stall_reason_c = SR_RS_FULL;
            default:      stall_reason_c = SR_NONE;
        endcase
    end

    assign bus.issue_valid  = issue_valid_q;
    assign bus.illegal      = illegal_q;
    assign bus.index_rb     = index_rb_q;
    assign bus.index_rs     = index_rs_q;
    assign bus.instruction  = instruction_q;
    assign bus.rs1          = rs1_q;
    assign bus.rs2          = rs2_q;
    assign bus.stall_reason = stall_reason_c;

`ifdef ISSUE_STATS_EN
    // Saturating statistics counters, untouched by flush
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue_go && stat_issued != '1) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (bus.in_valid && !ready && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: directed scenarios followed by
// randomized traffic, all checked against a rule-level reference model.
module tb_instr_issue_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    instr_issue_unit_if bus ();

`ifdef ISSUE_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_stall;
`endif

    instr_issue_unit dut (
        .clk   (clk),
        .rst_n (rst),
        .bus   (bus)
`ifdef ISSUE_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit [11:0]   m_alloc;
    int          m_tail;
    int          m_stall;
    logic        m_iv, m_ill;
    logic [2:0]  m_rb;
    logic [3:0]  m_rs;
    logic [31:0] m_ins;
    logic [31:0] m_issued, m_stalls;

    int cls_lo [3] = '{1, 7, 10};
    int cls_hi [3] = '{6, 9, 11};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // 0 LS, 1 ADD, 2 MUL, 3 illegal
    function automatic int cls_of(input logic [31:0] ins);
        logic [6:0] op = ins[6:0];
        logic [6:0] f7 = ins[31:25];
        if (op == 7'b0000011 || op == 7'b0100011) return 0;
        if (op == 7'b0010011) return 1;
        if (op == 7'b0110011) return (f7 == 7'b0000001) ? 2 : 1;
        return 3;
    endfunction

    function automatic int pick(input int c, input bit [11:0] a);
        if (c == 3) return 0;
        for (int id = cls_lo[c]; id <= cls_hi[c]; id++) begin
            if (!a[id]) return id;
        end
        return 0;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [4:0] r1, input logic [6:0] opc);
        return {f7, r2, r1, 3'b000, 5'd3, opc};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'b0000011;
            1: r[6:0] = 7'b0100011;
            2: begin r[6:0] = 7'b0110011; r[31:25] = 7'b0000000; end
            3: begin r[6:0] = 7'b0110011; r[31:25] = 7'b0000001; end
            4: r[6:0] = 7'b0010011;
            default: r[6:0] = ($urandom_range(0, 1) == 0) ? 7'b1111111 : 7'b0110111;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_alloc  = '0;
        m_tail   = 1;
        m_stall  = 0;
        m_iv     = 1'b0;
        m_ill    = 1'b0;
        m_rb     = '0;
        m_rs     = '0;
        m_ins    = '0;
        m_issued = '0;
        m_stalls = '0;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [7:0] busy,
                         input logic [11:0] rel, input logic fl);
        bus.in_valid   = v;
        bus.in_instr   = ins;
        bus.rob_busy   = busy;
        bus.rs_release = rel;
        bus.flush      = fl;
    endtask

    task automatic check_outs();
        logic [31:0] ins = m_ins;
        chk("issue_valid",  32'(bus.issue_valid),  32'(m_iv));
        chk("illegal",      32'(bus.illegal),      32'(m_ill));
        chk("index_rb",     32'(bus.index_rb),     32'(m_rb));
        chk("index_rs",     32'(bus.index_rs),     32'(m_rs));
        chk("instruction",  bus.instruction,       m_ins);
        chk("rs1",          32'(bus.rs1),          32'(ins[19:15]));
        chk("rs2",          32'(bus.rs2),          32'(ins[24:20]));
        chk("stall_reason", 32'(bus.stall_reason), 32'(m_stall));
`ifdef ISSUE_STATS_EN
        chk("stat_issued",  stat_issued,           m_issued);
        chk("stat_stall",   stat_stall,            m_stalls);
`endif
    endtask

    // One clock of traffic with the currently driven inputs
    task automatic step();
        int c, id;
        bit rob_ok, rs_ok, rdy, xfer;
        #1;
        c      = cls_of(bus.in_instr);
        id     = pick(c, m_alloc);
        rob_ok = !bus.rob_busy[m_tail];
        rs_ok  = (c == 3) || (id != 0);
        rdy    = rob_ok && rs_ok && !bus.flush;
        chk("in_ready", 32'(bus.in_ready), 32'(rdy));
        @(posedge clk);
        #1;
        xfer = bus.in_valid && rdy;
        if (xfer && c != 3 && m_issued != 32'hFFFF_FFFF) m_issued++;
        if (bus.in_valid && !rdy && m_stalls != 32'hFFFF_FFFF) m_stalls++;
        if (bus.flush) begin
            m_alloc = '0;
            m_tail  = 1;
            m_iv    = 1'b0;
            m_ill   = 1'b0;
            m_stall = 0;
        end else begin
            m_iv  = xfer && (c != 3);
            m_ill = xfer && (c == 3);
            m_alloc = m_alloc & ~bus.rs_release;
            if (m_iv) begin
                m_rb  = 3'(m_tail);
                m_rs  = 4'(id);
                m_ins = bus.in_instr;
                m_alloc[id] = 1'b1;
                m_tail = (m_tail + 1) % 8;
            end
            case (m_stall)
                0: begin
                    if (bus.in_valid && !rob_ok) m_stall = 1;
                    else if (bus.in_valid && !rs_ok) m_stall = 2;
                end
                1: if (rob_ok) m_stall = 0;
                default: begin
                    if (!rob_ok) m_stall = 1;
                    else if (rs_ok) m_stall = 0;
                end
            endcase
        end
        check_outs();
    endtask

    localparam logic [6:0] LOAD = 7'b0000011;
    localparam logic [6:0] OP   = 7'b0110011;

    initial begin
        logic [31:0] add_i, mul_i, ld_i;
        add_i = mk(7'd0, 5'd2, 5'd1, OP);
        mul_i = mk(7'd1, 5'd5, 5'd4, OP);
        ld_i  = mk(7'd0, 5'd0, 5'd9, LOAD);

        // Reset state
        drive(1'b0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_outs();
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;

        // 1: ADD x3,x1,x2 after reset
        drive(1'b1, add_i, '0, '0, 1'b0);
        step();
        chk("t1_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_rb",    32'(bus.index_rb),    32'd1);
        chk("t1_rs",    32'(bus.index_rs),    32'd7);
        chk("t1_rs1",   32'(bus.rs1),         32'd1);
        chk("t1_rs2",   32'(bus.rs2),         32'd2);
        drive(1'b0, '0, '0, '0, 1'b0);
        step();

        // 2: MUL class exhaustion and release
        drive(1'b1, mul_i, '0, '0, 1'b0);
        step();
        chk("t2_rs_a", 32'(bus.index_rs), 32'd10);
        step();
        chk("t2_rs_b", 32'(bus.index_rs), 32'd11);
        step();
        chk("t2_stall", 32'(bus.stall_reason), 32'd2);
        drive(1'b1, mul_i, '0, 12'h400, 1'b0);
        step();
        drive(1'b1, mul_i, '0, '0, 1'b0);
        step();
        chk("t2_rs_c", 32'(bus.index_rs), 32'd10);
        chk("t2_valid_c", 32'(bus.issue_valid), 32'd1);
        step();
        chk("t2_stall_d", 32'(bus.stall_reason), 32'd2);
        drive(1'b0, '0, '0, 12'hC80, 1'b0);
        step();
        drive(1'b0, '0, '0, '0, 1'b0);
        step();

        // 3: eight ADDs with per-cycle release, tail wrap, then ROB full
        drive(1'b0, '0, '0, '0, 1'b1);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mk(7'd0, 5'($urandom), 5'($urandom), OP), '0, 12'h380, 1'b0);
            step();
            chk("t3_rb", 32'(bus.index_rb), 32'((i + 1) % 8));
        end
        drive(1'b1, add_i, 8'h02, '0, 1'b0);
        step();
        chk("t3_ready", 32'(bus.in_ready), 32'd0);
        chk("t3_stall", 32'(bus.stall_reason), 32'd1);
        drive(1'b0, '0, '0, '0, 1'b0);
        step();

        // 4: illegal opcode consumed, tail unchanged
        drive(1'b1, 32'hFFFF_FFFF, '0, '0, 1'b0);
        step();
        chk("t4_illegal", 32'(bus.illegal), 32'd1);
        chk("t4_valid",   32'(bus.issue_valid), 32'd0);
        drive(1'b0, '0, '0, '0, 1'b0);
        step();
        chk("t4_illegal_off", 32'(bus.illegal), 32'd0);
        drive(1'b1, add_i, '0, '0, 1'b0);
        step();
        chk("t4_rb", 32'(bus.index_rb), 32'd1);

        // 5: flush with all LS allocated and tail at 5
        drive(1'b0, '0, '0, '0, 1'b1);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, mk(7'd0, 5'($urandom), 5'($urandom), LOAD), '0, '0, 1'b0);
            step();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, add_i, '0, 12'h380, 1'b0);
            step();
        end
        chk("t5_tail5", 32'(bus.index_rb), 32'd4);
        drive(1'b1, ld_i, '0, '0, 1'b1);
        step();
        drive(1'b1, ld_i, '0, '0, 1'b0);
        step();
        chk("t5_rs", 32'(bus.index_rs), 32'd1);
        chk("t5_rb", 32'(bus.index_rb), 32'd1);
        drive(1'b1, add_i, '0, '0, 1'b0);
        step();
        chk("t5_add_rs", 32'(bus.index_rs), 32'd7);

        // 6: asynchronous reset in the middle of a ROB stall
        drive(1'b1, add_i, 8'hFF, '0, 1'b0);
        step();
        step();
        chk("t6_pre_stall", 32'(bus.stall_reason), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outs();
        drive(1'b0, '0, '0, '0, 1'b0);
        #1;
        chk("t6_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, add_i, '0, '0, 1'b0);
        step();
        chk("t6_rb", 32'(bus.index_rb), 32'd1);
        chk("t6_rs", 32'(bus.index_rs), 32'd7);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0]  busy;
            logic [11:0] rel;
            busy = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            rel  = ($urandom_range(0, 1) == 0) ? (12'($urandom) & 12'hFFE) : 12'h000;
            drive($urandom_range(0, 3) != 0, rand_instr(), busy, rel,
                  $urandom_range(0, 31) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
